// File: rtl/approx_rc_adder_pipe.sv
// Pipelined lower-part-OR approximate adder with run-time approximate LSB count
// and a saturating error monitor on delivered results.
module approx_rc_adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int MAX_K  = 4,
  parameter int STAGES = 2,
  parameter int ERR_W  = 32,
  localparam int KW    = (MAX_K > 0) ? $clog2(MAX_K + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] err_abs_sum
);

  localparam int L  = STAGES - 1;
  localparam int AW = (ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1;
  localparam logic [AW:0] ERR_MAX_EXT = {{(AW + 1 - ERR_W){1'b0}}, {ERR_W{1'b1}}};

  int               keff;
  logic             c;
  logic [WIDTH-1:0] apx_s;
  logic [WIDTH:0]   apx_in;
  logic [WIDTH:0]   ext_in;

  logic [WIDTH:0]   st_apx [STAGES];
  logic [WIDTH:0]   st_ext [STAGES];
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] ld;

  logic             xfer;
  logic [WIDTH:0]   abs_err;
  logic [AW:0]      abs_sum_nx;

  // Bits below keff are OR-ed; the top bit of that region generates the carry
  // into the exact upper ripple. With keff == 0 the chain starts from cin.
  always_comb begin
    keff  = (int'(k) > MAX_K) ? MAX_K : int'(k);
    c     = cin;
    apx_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < keff) begin
        apx_s[i] = a[i] | b[i] | ((i == 0) & cin);
        c        = a[i] & b[i];
      end else begin
        apx_s[i] = a[i] ^ b[i] ^ c;
        c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    apx_in = {c, apx_s};
    ext_in = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  // A stage may load whenever the output drains or any stage from it
  // downstream has a hole, so the chain is computed without self-reference.
  always_comb begin
    ld = '0;
    for (int i = 0; i < STAGES; i++) begin
      ld[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!st_v[j]) ld[i] = 1'b1;
      end
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        st_apx[i] <= '0;
        st_ext[i] <= '0;
      end
    end else begin
      if (ld[0]) begin
        st_v[0] <= in_valid;
        if (in_valid) begin
          st_apx[0] <= apx_in;
          st_ext[0] <= ext_in;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) begin
          st_v[i] <= st_v[i-1];
          if (st_v[i-1]) begin
            st_apx[i] <= st_apx[i-1];
            st_ext[i] <= st_ext[i-1];
          end
        end
      end
    end
  end

  assign out_valid = st_v[L];
  assign s         = st_apx[L][WIDTH-1:0];
  assign cout      = st_apx[L][WIDTH];

  assign xfer    = st_v[L] & out_ready;
  assign abs_err = (st_ext[L] >= st_apx[L]) ? (st_ext[L] - st_apx[L])
                                            : (st_apx[L] - st_ext[L]);
  assign abs_sum_nx = {{(AW + 1 - ERR_W){1'b0}}, err_abs_sum}
                    + {{(AW - WIDTH){1'b0}}, abs_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      err_abs_sum <= '0;
    end else if (err_clr) begin
      err_count   <= '0;
      err_abs_sum <= '0;
    end else if (xfer) begin
      if ((st_apx[L] != st_ext[L]) && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;
      if (abs_sum_nx > ERR_MAX_EXT)
        err_abs_sum <= {ERR_W{1'b1}};
      else
        err_abs_sum <= abs_sum_nx[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Directed bench for approx_rc_adder_pipe (WIDTH=8, MAX_K=4, STAGES=2).
module tb_approx_rc_adder_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [2:0] k;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       err_clr;
  logic [31:0] err_count;
  logic [31:0] err_abs_sum;

  int checks;
  int errors;

  approx_rc_adder_pipe #(.WIDTH(8), .MAX_K(4), .STAGES(2), .ERR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .err_clr(err_clr), .err_count(err_count),
    .err_abs_sum(err_abs_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic drive_beat(input logic [7:0] va, input logic [7:0] vb,
                            input logic vc, input logic [2:0] vk);
    int n;
    a = va; b = vb; cin = vc; k = vk; in_valid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL drive_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b s=%h cout=%b expected 0 0 0", out_valid, s, cout);
    end
    checks++;
    if (err_count !== 32'd0 || err_abs_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_err: count=%0d abs=%0d expected 0 0", err_count, err_abs_sum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_exact_exhaustive();
    out_ready = 1'b1; cin = 1'b0; k = 3'd0;
    fork
      begin
        for (int n = 0; n < 65536; n++) begin
          a = n[15:8]; b = n[7:0]; in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int idx;
        int cyc;
        logic [8:0] exp_sum;
        idx = 0; cyc = 0;
        while (idx < 65536 && cyc < 70000) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            exp_sum = {1'b0, idx[15:8]} + {1'b0, idx[7:0]};
            checks++;
            if ({cout, s} !== exp_sum) begin
              errors++;
              $display("FAIL exact_sum: beat %0d got %h expected %h", idx, {cout, s}, exp_sum);
            end
            idx++;
          end
        end
        if (idx < 65536) begin
          checks++; errors++;
          $display("FAIL exact_timeout: got %0d results expected 65536", idx);
        end
      end
    join
    @(posedge clk); #1;
    checks++;
    if (err_count !== 32'd0 || err_abs_sum !== 32'd0) begin
      errors++;
      $display("FAIL exact_err: count=%0d abs=%0d expected 0 0", err_count, err_abs_sum);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; cin = 1'b1; k = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h047) begin
      errors++;
      $display("FAIL latency_t2: out_valid=%b sum=%h expected 1 047", out_valid, {cout, s});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_k3_or();
    int n;
    out_ready = 1'b1;
    pulse_clr();
    checks++;
    if (err_count !== 32'd0 || err_abs_sum !== 32'd0) begin
      errors++;
      $display("FAIL clr_zero: count=%0d abs=%0d expected 0 0", err_count, err_abs_sum);
    end
    drive_beat(8'h07, 8'h01, 1'b0, 3'd3);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h007) begin
      errors++;
      $display("FAIL k3_07_01: valid=%b sum=%h expected 1 007", out_valid, {cout, s});
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 32'd1 || err_abs_sum !== 32'd1) begin
      errors++;
      $display("FAIL k3_err1: count=%0d abs=%0d expected 1 1", err_count, err_abs_sum);
    end
    drive_beat(8'h04, 8'h04, 1'b0, 3'd3);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h00C) begin
      errors++;
      $display("FAIL k3_04_04: valid=%b sum=%h expected 1 00c", out_valid, {cout, s});
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 32'd2 || err_abs_sum !== 32'd5) begin
      errors++;
      $display("FAIL k3_err2: count=%0d abs=%0d expected 2 5", err_count, err_abs_sum);
    end
    drive_beat(8'hFF, 8'hFF, 1'b1, 3'd3);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h1FF) begin
      errors++;
      $display("FAIL k3_ff_ff: valid=%b sum=%h expected 1 1ff", out_valid, {cout, s});
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 32'd2 || err_abs_sum !== 32'd5) begin
      errors++;
      $display("FAIL k3_err_hold: count=%0d abs=%0d expected 2 5", err_count, err_abs_sum);
    end
  endtask

  task automatic test_clamp();
    int n;
    out_ready = 1'b1;
    drive_beat(8'h1F, 8'h01, 1'b0, 3'd7);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h01F) begin
      errors++;
      $display("FAIL clamp_k7: valid=%b sum=%h expected 1 01f", out_valid, {cout, s});
    end
    @(posedge clk); #1;
    drive_beat(8'h1F, 8'h01, 1'b0, 3'd4);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h01F) begin
      errors++;
      $display("FAIL clamp_k4: valid=%b sum=%h expected 1 01f", out_valid, {cout, s});
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 32'd4 || err_abs_sum !== 32'd7) begin
      errors++;
      $display("FAIL clamp_err: count=%0d abs=%0d expected 4 7", err_count, err_abs_sum);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    b = 8'h00; cin = 1'b0; k = 3'd0;
    a = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready1: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    a = 8'd2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready2: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    a = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || s !== 8'd1) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d in_ready=%b valid=%b s=%0d expected 0 1 1",
                 i, in_ready, out_valid, s);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_out1: valid=%b s=%0d in_ready=%b expected 1 1 1", out_valid, s, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'd2) begin
      errors++;
      $display("FAIL bp_out2: valid=%b s=%0d expected 1 2", out_valid, s);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'd3) begin
      errors++;
      $display("FAIL bp_out3: valid=%b s=%0d expected 1 3", out_valid, s);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 5; i++) drive_beat(8'h07, 8'h01, 1'b0, 3'd3);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 32'd5 || err_abs_sum !== 32'd5) begin
      errors++;
      $display("FAIL mid_pre: count=%0d abs=%0d expected 5 5", err_count, err_abs_sum);
    end
    out_ready = 1'b0;
    drive_beat(8'h01, 8'h01, 1'b0, 3'd0);
    drive_beat(8'h02, 8'h02, 1'b0, 3'd0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 32'd0 || err_abs_sum !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b count=%0d abs=%0d expected 0 0 0",
               out_valid, err_count, err_abs_sum);
    end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_clr_priority();
    int n;
    out_ready = 1'b1;
    drive_beat(8'h07, 8'h01, 1'b0, 3'd3);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 32'd1) begin
      errors++;
      $display("FAIL clr_pre: count=%0d expected 1", err_count);
    end
    out_ready = 1'b0;
    drive_beat(8'h04, 8'h04, 1'b0, 3'd3);
    @(negedge clk); n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || {cout, s} !== 9'h00C) begin
      errors++;
      $display("FAIL clr_held: valid=%b sum=%h expected 1 00c", out_valid, {cout, s});
    end
    out_ready = 1'b1;
    err_clr   = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (err_count !== 32'd0 || err_abs_sum !== 32'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio: count=%0d abs=%0d valid=%b expected 0 0 0",
               err_count, err_abs_sum, out_valid);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; k = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    test_reset();
    test_exact_exhaustive();
    test_latency();
    test_k3_or();
    test_clamp();
    test_back_to_back();
    test_reset_midstream();
    test_clr_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
